// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-side frame controller: FSM states,
// error cause codes and the default frame start marker.
package uart_pkg;

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_HOLD
    } rx_state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    localparam logic [1:0] ERR_CHECKSUM = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_LENGTH   = 2'b11;

endpackage

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind a UART receiver: finds SYNC_BYTE, collects LEN payload
// bytes, verifies the checksum and holds the good frame until the consumer acks.
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int unsigned MAX_LEN      = 16,
    parameter logic [15:0] TIMEOUT_CLKS = 16'd8680
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    input  logic [3:0] i_Rd_Addr,
    input  logic       i_Frame_Ack,
    output logic       o_Frame_Valid,
    output logic [4:0] o_Frame_Len,
    output logic [7:0] o_Rd_Data,
    output logic       o_Err,
    output logic [1:0] o_Err_Code,
    output logic       o_Overrun
);

    localparam int unsigned AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]  LEN_MAX = 8'(MAX_LEN);

    rx_state_e   r_state;
    rx_state_e   w_state_next;
    logic [4:0]  r_len;
    logic [4:0]  w_len_next;
    logic [4:0]  r_idx;
    logic [4:0]  w_idx_next;
    logic [7:0]  r_acc;
    logic [7:0]  w_acc_next;
    logic [15:0] r_gap;
    logic [15:0] w_gap_next;
    logic        r_err;
    logic        w_err_next;
    logic [1:0]  r_err_code;
    logic [1:0]  w_err_code_next;
    logic        r_ovr;
    logic        w_ovr_next;
    logic [7:0]  r_rd_data;
    logic        w_wr_en;
    logic        w_active;
    logic        w_timeout;
    logic        w_last;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;

    logic [7:0]  r_buf [MAX_LEN];

    assign w_active  = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHK);
    // A byte in the very cycle the gap expires wins over the timeout.
    assign w_timeout = w_active && !i_Rx_DV && (r_gap == TIMEOUT_CLKS - 16'd1);
    assign w_last    = (r_idx == r_len - 5'd1);
    assign w_wr_idx  = AW'(r_idx);
    assign w_rd_idx  = AW'(i_Rd_Addr);

    always_comb begin
        w_state_next    = r_state;
        w_len_next      = r_len;
        w_idx_next      = r_idx;
        w_acc_next      = r_acc;
        w_err_next      = 1'b0;
        w_err_code_next = r_err_code;
        w_ovr_next      = 1'b0;
        w_wr_en         = 1'b0;

        unique case (r_state)
            S_HUNT: begin
                if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
                    w_state_next = S_LEN;
                end
            end
            S_LEN: begin
                if (i_Rx_DV) begin
                    if ((i_Rx_Byte == 8'd0) || (i_Rx_Byte > LEN_MAX)) begin
                        w_err_next      = 1'b1;
                        w_err_code_next = ERR_LENGTH;
                        w_state_next    = S_HUNT;
                    end else begin
                        w_len_next   = i_Rx_Byte[4:0];
                        w_acc_next   = i_Rx_Byte;
                        w_idx_next   = 5'd0;
                        w_state_next = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (i_Rx_DV) begin
                    w_wr_en    = 1'b1;
                    w_acc_next = r_acc + i_Rx_Byte;
                    w_idx_next = r_idx + 5'd1;
                    if (w_last) begin
                        w_state_next = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte == r_acc) begin
                        w_state_next = S_HOLD;
                    end else begin
                        w_err_next      = 1'b1;
                        w_err_code_next = ERR_CHECKSUM;
                        w_state_next    = S_HUNT;
                    end
                end
            end
            S_HOLD: begin
                // Ack frees the buffer in the same cycle, so a coincident byte is hunted.
                if (i_Frame_Ack) begin
                    w_state_next = (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) ? S_LEN : S_HUNT;
                end else if (i_Rx_DV) begin
                    w_ovr_next = 1'b1;
                end
            end
            default: begin
                w_state_next = S_HUNT;
            end
        endcase

        if (w_timeout) begin
            w_err_next      = 1'b1;
            w_err_code_next = ERR_TIMEOUT;
            w_state_next    = S_HUNT;
        end

        if (i_Rx_DV || !w_active || w_timeout) begin
            w_gap_next = 16'd0;
        end else begin
            w_gap_next = r_gap + 16'd1;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state    <= S_HUNT;
            r_len      <= 5'd0;
            r_idx      <= 5'd0;
            r_acc      <= 8'd0;
            r_gap      <= 16'd0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
            r_ovr      <= 1'b0;
            r_rd_data  <= 8'd0;
        end else begin
            r_state    <= w_state_next;
            r_len      <= w_len_next;
            r_idx      <= w_idx_next;
            r_acc      <= w_acc_next;
            r_gap      <= w_gap_next;
            r_err      <= w_err_next;
            r_err_code <= w_err_code_next;
            r_ovr      <= w_ovr_next;
            r_rd_data  <= r_buf[w_rd_idx];
        end
    end

    // Payload storage is deliberately left out of reset.
    always_ff @(posedge i_Clock) begin
        if (w_wr_en) begin
            r_buf[w_wr_idx] <= i_Rx_Byte;
        end
    end

    assign o_Frame_Valid = (r_state == S_HOLD);
    assign o_Frame_Len   = (r_state == S_HOLD) ? r_len : 5'd0;
    assign o_Rd_Data     = r_rd_data;
    assign o_Err         = r_err;
    assign o_Err_Code    = r_err_code;
    assign o_Overrun     = r_ovr;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: directed frames with literal expectations, then
// random frame traffic, all compared every cycle against a byte-level frame model.
module tb_uart_rx_frame_ctrl;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int MAXL = 16;
    localparam int TO   = 8680;

    logic       clk;
    logic       rst_n;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic [3:0] rd_addr;
    logic       ack;
    logic       frame_valid;
    logic [4:0] frame_len;
    logic [7:0] rd_data;
    logic       err;
    logic [1:0] err_code;
    logic       overrun;

    int n_checks = 0;
    int n_pass   = 0;
    bit rand_addr = 0;

    uart_rx_frame_ctrl dut (
        .i_Clock      (clk),
        .i_Rst_n      (rst_n),
        .i_Rx_DV      (rx_dv),
        .i_Rx_Byte    (rx_byte),
        .i_Rd_Addr    (rd_addr),
        .i_Frame_Ack  (ack),
        .o_Frame_Valid(frame_valid),
        .o_Frame_Len  (frame_len),
        .o_Rd_Data    (rd_data),
        .o_Err        (err),
        .o_Err_Code   (err_code),
        .o_Overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural frame model ----------------
    bit          m_hold, m_coll, m_have_len;
    int unsigned m_len, m_hold_len;
    byte unsigned m_pl[$];
    longint      m_cyc = 0, m_last_dv = 0;
    logic [7:0]  m_buf [16];
    bit          m_known [16];
    bit          exp_valid, exp_err, exp_ovr, exp_rd_known;
    logic [4:0]  exp_len;
    logic [1:0]  exp_code;
    logic [7:0]  exp_rd;

    task automatic model_reset();
        m_hold = 0; m_coll = 0; m_have_len = 0; m_pl.delete();
        exp_valid = 0; exp_len = 0; exp_err = 0; exp_code = 0; exp_ovr = 0;
        exp_rd = 0; exp_rd_known = 1;
    endtask

    task automatic model_start();
        m_coll = 1; m_have_len = 0; m_pl.delete(); m_last_dv = m_cyc;
    endtask

    task automatic model_err(input logic [1:0] code);
        exp_err = 1; exp_code = code; m_coll = 0;
    endtask

    task automatic model_step();
        int unsigned s;
        logic [7:0] b;
        b = rx_byte;
        exp_rd_known = m_known[rd_addr];
        exp_rd = m_buf[rd_addr];
        exp_err = 0;
        exp_ovr = 0;
        m_cyc++;
        if (m_hold) begin
            if (ack) begin
                m_hold = 0;
                if (rx_dv && b == SYNC) model_start();
            end else if (rx_dv) begin
                exp_ovr = 1;
            end
        end else if (m_coll) begin
            if (rx_dv) begin
                m_last_dv = m_cyc;
                if (!m_have_len) begin
                    if (b == 0 || b > MAXL) model_err(2'b11);
                    else begin m_have_len = 1; m_len = b; end
                end else if (m_pl.size() < m_len) begin
                    m_buf[m_pl.size()] = b;
                    m_known[m_pl.size()] = 1;
                    m_pl.push_back(b);
                end else begin
                    s = m_len;
                    foreach (m_pl[i]) s += m_pl[i];
                    if (b == 8'(s)) begin m_hold = 1; m_hold_len = m_len; m_coll = 0; end
                    else model_err(2'b01);
                end
            end else if (m_cyc - m_last_dv >= TO) begin
                model_err(2'b10);
            end
        end else if (rx_dv && b == SYNC) begin
            model_start();
        end
        exp_valid = m_hold;
        exp_len = m_hold ? 5'(m_hold_len) : 5'd0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("valid", 32'(frame_valid), 32'(exp_valid));
            check("len", 32'(frame_len), 32'(exp_len));
            check("err", 32'(err), 32'(exp_err));
            check("err_code", 32'(err_code), 32'(exp_code));
            check("overrun", 32'(overrun), 32'(exp_ovr));
            if (exp_rd_known) check("rd_data", 32'(rd_data), 32'(exp_rd));
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_addr) rd_addr = 4'($urandom_range(0, 15));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic dv, input logic [7:0] b, input logic a);
        rx_dv = dv; rx_byte = b; ack = a;
        @(posedge clk);
        #1;
        rx_dv = 1'b0; ack = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        drive(1'b1, b, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic rd_check(input logic [3:0] a, input logic [7:0] e);
        rd_addr = a;
        @(posedge clk);
        #1;
        check("rd_lit", 32'(rd_data), 32'(e));
    endtask

    task automatic send_good_a();
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
    endtask

    task automatic send_random_frame();
        int kind;
        int len;
        int unsigned s;
        logic [7:0] fr[$];
        logic [7:0] v;
        kind = $urandom_range(0, 9);
        if (kind == 8) begin
            repeat ($urandom_range(1, 4)) fr.push_back(8'($urandom_range(0, 255)));
        end else begin
            if (kind == 7) len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 255);
            else len = $urandom_range(1, MAXL);
            fr.push_back(SYNC);
            fr.push_back(8'(len));
            if (kind != 7) begin
                s = len;
                for (int i = 0; i < len; i++) begin
                    v = 8'($urandom_range(0, 255));
                    fr.push_back(v);
                    s += v;
                end
                if (kind == 6) fr.push_back(8'(s) ^ 8'($urandom_range(1, 255)));
                else fr.push_back(8'(s));
                if (kind == 9) void'(fr.pop_back());
            end
        end
        foreach (fr[i]) begin
            repeat ($urandom_range(0, 3)) drive(1'b0, 8'h00, $urandom_range(0, 3) == 0);
            drive(1'b1, fr[i], $urandom_range(0, 7) == 0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00; ack = 1'b0; rd_addr = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_rd", 32'(rd_data), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Good frame, readback, ack.
        send_good_a();
        check("good_valid", 32'(frame_valid), 32'd1);
        check("good_len", 32'(frame_len), 32'd3);
        rd_check(4'd0, 8'h11);
        rd_check(4'd1, 8'h22);
        rd_check(4'd2, 8'h33);
        drive(1'b0, 8'h00, 1'b1);
        check("ack_valid", 32'(frame_valid), 32'd0);

        // Bad checksum, then recovery.
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h68);
        check("chk_err", 32'(err), 32'd1);
        check("chk_code", 32'(err_code), 32'h1);
        check("chk_valid", 32'(frame_valid), 32'd0);
        idle(1);
        check("chk_err_pulse", 32'(err), 32'd0);
        send_good_a();
        check("recover_valid", 32'(frame_valid), 32'd1);
        drive(1'b0, 8'h00, 1'b1);

        // Length errors.
        send(8'hA5); send(8'h00);
        check("len0_err", 32'(err), 32'd1);
        check("len0_code", 32'(err_code), 32'h3);
        send(8'hA5); send(8'h11);
        check("len17_err", 32'(err), 32'd1);
        check("len17_code", 32'(err_code), 32'h3);
        send(8'h01); send(8'h01); send(8'h02);
        check("len_hunt_valid", 32'(frame_valid), 32'd0);

        // Byte exactly at the timeout cycle suppresses the error.
        send(8'hA5); send(8'h02); send(8'h11);
        idle(TO - 1);
        send(8'h22);
        check("to_suppress_err", 32'(err), 32'd0);
        send(8'h35);
        check("to_suppress_valid", 32'(frame_valid), 32'd1);
        drive(1'b0, 8'h00, 1'b1);

        // Real timeout.
        send(8'hA5); send(8'h02); send(8'h11);
        idle(TO - 1);
        check("to_early", 32'(err), 32'd0);
        idle(1);
        check("to_err", 32'(err), 32'd1);
        check("to_code", 32'(err_code), 32'h2);
        idle(1);
        check("to_code_hold", 32'(err_code), 32'h2);

        // Overrun, then sync together with ack.
        send_good_a();
        send(8'h55);
        check("ovr_pulse", 32'(overrun), 32'd1);
        idle(1);
        check("ovr_once", 32'(overrun), 32'd0);
        rd_check(4'd0, 8'h11);
        rd_check(4'd2, 8'h33);
        check("ovr_still_valid", 32'(frame_valid), 32'd1);
        drive(1'b1, 8'hA5, 1'b1);
        check("ackdv_ovr", 32'(overrun), 32'd0);
        check("ackdv_valid", 32'(frame_valid), 32'd0);
        send(8'h01); send(8'h7E); send(8'h7F);
        check("ackdv_frame", 32'(frame_valid), 32'd1);
        check("ackdv_len", 32'(frame_len), 32'd1);
        drive(1'b0, 8'h00, 1'b1);

        // Reset mid-frame.
        send(8'hA5); send(8'h04); send(8'h11);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(frame_valid), 32'd0);
        check("rst_mid_code", 32'(err_code), 32'd0);
        check("rst_mid_rd", 32'(rd_data), 32'd0);
        idle(2);
        rst_n = 1'b1;
        send(8'h22); send(8'h33); send(8'h44); send(8'h5B);
        check("rst_discard", 32'(frame_valid), 32'd0);
        send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
        check("rst_after_valid", 32'(frame_valid), 32'd1);
        rd_check(4'd0, 8'h7E);
        drive(1'b0, 8'h00, 1'b1);

        // Random traffic.
        rand_addr = 1;
        repeat (300) send_random_frame();
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
